// File: rtl/cpu_defs_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_defs_pkg: shared CPU datapath widths and write-back source encoding    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_defs_pkg;

    localparam int          DATA_W     = 32;
    localparam int          REG_ADDR_W = 5;
    localparam int          NUM_REGS   = 32;
    localparam int          STARVE_MAX = 4;
    localparam logic [4:0]  REG_ZERO   = 5'd0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// +----------------------------------------------------------------------------+
// | wb_scoreboard: pending-destination mask for LSU ops, issue grant, error    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_scoreboard #(
    parameter int ADDR_W   = cpu_defs_pkg::REG_ADDR_W,
    parameter int NUM_REGS = cpu_defs_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_valid_i,
    input  logic [ADDR_W-1:0]   set_addr_i,
    input  logic                clr_valid_i,
    input  logic [ADDR_W-1:0]   clr_addr_i,
    output logic                issue_accept_o,
    output logic [NUM_REGS-1:0] pending_mask_o,
    output logic                lsu_error_o
);
    import cpu_defs_pkg::*;

    localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]   ZERO_A   = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                error_q, error_d;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_clr_vec;

    // Register 0 is never marked pending, so reservations of it always pass.
    assign issue_accept_o = rst_n & set_valid_i & ~pending_q[set_addr_i];

    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (issue_accept_o && (set_addr_i != ZERO_A)) begin
            w_set_vec = ONE_HOT0 << set_addr_i;
        end
        if (clr_valid_i) begin
            w_clr_vec = ONE_HOT0 << clr_addr_i;
        end
        pending_d = (pending_q & ~w_clr_vec) | w_set_vec;
        error_d   = error_q |
                    (clr_valid_i && (clr_addr_i != ZERO_A) && !pending_q[clr_addr_i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            error_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            error_q   <= error_d;
        end
    end

    assign pending_mask_o = pending_q;
    assign lsu_error_o    = error_q;

endmodule

`default_nettype wire

// File: rtl/reg_writeback_arbiter.sv
// +----------------------------------------------------------------------------+
// | reg_writeback_arbiter: ALU/LSU write-port arbiter with starvation bubble   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_writeback_arbiter #(
    parameter int DATA_W     = cpu_defs_pkg::DATA_W,
    parameter int ADDR_W     = cpu_defs_pkg::REG_ADDR_W,
    parameter int STARVE_MAX = cpu_defs_pkg::STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluRegAddr,
    input  logic [DATA_W-1:0] aluData,
    input  logic              lsuValid,
    output logic              lsuReady,
    input  logic [ADDR_W-1:0] lsuRegAddr,
    input  logic [DATA_W-1:0] lsuData,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueRegAddr,
    output logic              issueAccept,
    output logic              aluStall,
    output logic              regWriteEnable,
    output logic [ADDR_W-1:0] writeRegAddr,
    output logic [DATA_W-1:0] writeData,
    output logic [31:0]       pendingMask,
    output logic              lsuError
);
    import cpu_defs_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_A    = ADDR_W'(REG_ZERO);
    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

    wb_src_e           w_src;
    logic              w_lsu_xfer;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        starve_q, starve_d;
    logic              stall_q, stall_d;

    assign lsuReady   = rst_n & ~aluValid;
    assign w_lsu_xfer = lsuValid & lsuReady;

    always_comb begin
        w_src = SRC_NONE;
        if (aluValid) begin
            w_src = SRC_ALU;
        end else if (w_lsu_xfer) begin
            w_src = SRC_LSU;
        end
    end

    // Idle cycles keep the last address/data so the register file bus stays quiet.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        case (w_src)
            SRC_ALU: begin
                addr_d = aluRegAddr;
                data_d = aluData;
                we_d   = (aluRegAddr != ZERO_A);
            end
            SRC_LSU: begin
                addr_d = lsuRegAddr;
                data_d = lsuData;
                we_d   = (lsuRegAddr != ZERO_A);
            end
            default: ;
        endcase
    end

    // Counts consecutive cycles the LSU was offered but lost to the ALU.
    always_comb begin
        stall_d  = (starve_q == STARVE_LIM);
        starve_d = starve_q;
        if (stall_d || !lsuValid || w_lsu_xfer) begin
            starve_d = 4'd0;
        end else if (aluValid) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            starve_q <= 4'd0;
            stall_q  <= 1'b0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    wb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (32)
    ) u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_valid_i    (issueValid),
        .set_addr_i     (issueRegAddr),
        .clr_valid_i    (w_lsu_xfer),
        .clr_addr_i     (lsuRegAddr),
        .issue_accept_o (issueAccept),
        .pending_mask_o (pendingMask),
        .lsu_error_o    (lsuError)
    );

    assign regWriteEnable = we_q;
    assign writeRegAddr   = addr_q;
    assign writeData      = data_q;
    assign aluStall       = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_reg_writeback_arbiter: directed and randomized checks against a model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reg_writeback_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aluValid = 1'b0;
    logic [4:0]  aluRegAddr = '0;
    logic [31:0] aluData = '0;
    logic        lsuValid = 1'b0;
    logic        lsuReady;
    logic [4:0]  lsuRegAddr = '0;
    logic [31:0] lsuData = '0;
    logic        issueValid = 1'b0;
    logic [4:0]  issueRegAddr = '0;
    logic        issueAccept;
    logic        aluStall;
    logic        regWriteEnable;
    logic [4:0]  writeRegAddr;
    logic [31:0] writeData;
    logic [31:0] pendingMask;
    logic        lsuError;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_mask;
    logic        m_err;
    logic        m_stall;
    int          m_blocked;
    logic        m_last_xfer;

    reg_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .aluValid(aluValid), .aluRegAddr(aluRegAddr), .aluData(aluData),
        .lsuValid(lsuValid), .lsuReady(lsuReady), .lsuRegAddr(lsuRegAddr), .lsuData(lsuData),
        .issueValid(issueValid), .issueRegAddr(issueRegAddr), .issueAccept(issueAccept),
        .aluStall(aluStall), .regWriteEnable(regWriteEnable), .writeRegAddr(writeRegAddr),
        .writeData(writeData), .pendingMask(pendingMask), .lsuError(lsuError)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return rst_n && !aluValid;
    endfunction

    function automatic logic exp_accept();
        return rst_n && issueValid && (issueRegAddr == 5'd0 || !m_mask[issueRegAddr]);
    endfunction

    task automatic model_reset();
        m_we = 0; m_addr = 0; m_data = 0; m_mask = 0; m_err = 0; m_stall = 0;
        m_blocked = 0; m_last_xfer = 0;
    endtask

    // Advance one clock and apply the write-back rules to the model.
    task automatic tick();
        logic        xfer, acc, n_we, n_stall, n_err;
        logic [4:0]  n_addr;
        logic [31:0] n_data, n_mask;
        int          n_blocked;
        xfer = lsuValid && exp_ready();
        acc  = exp_accept();
        n_we = 0; n_addr = m_addr; n_data = m_data;
        if (aluValid) begin
            n_we = (aluRegAddr != 0); n_addr = aluRegAddr; n_data = aluData;
        end else if (xfer) begin
            n_we = (lsuRegAddr != 0); n_addr = lsuRegAddr; n_data = lsuData;
        end
        n_mask = m_mask;
        if (xfer) n_mask[lsuRegAddr] = 1'b0;
        if (acc && issueRegAddr != 0) n_mask[issueRegAddr] = 1'b1;
        n_err = m_err || (xfer && lsuRegAddr != 0 && !m_mask[lsuRegAddr]);
        n_stall = (m_blocked == SMAX);
        if (n_stall || !lsuValid || xfer) n_blocked = 0;
        else n_blocked = m_blocked + 1;
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_we = n_we; m_addr = n_addr; m_data = n_data; m_mask = n_mask;
            m_err = n_err; m_stall = n_stall; m_blocked = n_blocked; m_last_xfer = xfer;
        end else begin
            model_reset();
        end
    endtask

    task automatic idle_inputs();
        aluValid = 0; lsuValid = 0; issueValid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; aluValid = 1; aluRegAddr = 5'd3; aluData = 32'h1111_2222;
        issueValid = 1; issueRegAddr = 5'd2; lsuValid = 1; lsuRegAddr = 5'd2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({regWriteEnable, writeRegAddr, writeData, pendingMask, lsuError, aluStall} !== '0) begin
            bad++; $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h mask=%h err=%0b stall=%0b want all 0",
                regWriteEnable, writeRegAddr, writeData, pendingMask, lsuError, aluStall);
        end
        total++;
        if (lsuReady !== 1'b0 || issueAccept !== 1'b0) begin
            bad++; $display("FAIL reset_handshake: got lsuReady=%0b issueAccept=%0b want 0 0", lsuReady, issueAccept);
        end
        rst_n = 1; lsuValid = 0; issueValid = 0;
        aluValid = 1; aluRegAddr = 5'd3; aluData = 32'hDEADBEEF;
        tick();
        aluValid = 0;
        total++;
        if (regWriteEnable !== 1'b1 || writeRegAddr !== 5'd3 || writeData !== 32'hDEADBEEF) begin
            bad++; $display("FAIL first_alu_write: got we=%0b addr=%0d data=%h want 1 3 deadbeef",
                regWriteEnable, writeRegAddr, writeData);
        end
    endtask

    task automatic test_collision();
        issueValid = 1; issueRegAddr = 5'd7;
        aluValid = 1; aluRegAddr = 5'd4; aluData = 32'hA5A5_0004;
        lsuValid = 1; lsuRegAddr = 5'd7; lsuData = 32'h1234_5678;
        #1;
        total++;
        if (lsuReady !== 1'b0 || issueAccept !== 1'b1) begin
            bad++; $display("FAIL collision_ready: got lsuReady=%0b accept=%0b want 0 1", lsuReady, issueAccept);
        end
        tick();
        total++;
        if (regWriteEnable !== 1'b1 || writeRegAddr !== 5'd4 || writeData !== 32'hA5A5_0004 || pendingMask !== 32'h80) begin
            bad++; $display("FAIL collision_alu_first: got we=%0b addr=%0d data=%h mask=%h want 1 4 a5a50004 00000080",
                regWriteEnable, writeRegAddr, writeData, pendingMask);
        end
        issueValid = 0; aluValid = 0;
        #1;
        total++;
        if (lsuReady !== 1'b1) begin
            bad++; $display("FAIL collision_lsu_ready: got %0b want 1", lsuReady);
        end
        tick();
        lsuValid = 0;
        total++;
        if (regWriteEnable !== 1'b1 || writeRegAddr !== 5'd7 || writeData !== 32'h1234_5678 ||
            pendingMask !== 32'h0 || lsuError !== 1'b0) begin
            bad++; $display("FAIL collision_lsu_write: got we=%0b addr=%0d data=%h mask=%h err=%0b want 1 7 12345678 0 0",
                regWriteEnable, writeRegAddr, writeData, pendingMask, lsuError);
        end
        tick();
        total++;
        if (regWriteEnable !== 1'b0 || writeRegAddr !== 5'd7 || writeData !== 32'h1234_5678) begin
            bad++; $display("FAIL idle_hold: got we=%0b addr=%0d data=%h want 0 7 12345678",
                regWriteEnable, writeRegAddr, writeData);
        end
    endtask

    task automatic test_scoreboard();
        issueValid = 1; issueRegAddr = 5'd9;
        #1;
        total++;
        if (issueAccept !== 1'b1) begin
            bad++; $display("FAIL issue9_accept: got %0b want 1", issueAccept);
        end
        tick();
        total++;
        if (pendingMask !== 32'h200) begin
            bad++; $display("FAIL issue9_mask: got %h want 00000200", pendingMask);
        end
        total++;
        if (issueAccept !== 1'b0) begin
            bad++; $display("FAIL issue9_again: got accept=%0b want 0", issueAccept);
        end
        issueValid = 0; lsuValid = 1; lsuRegAddr = 5'd9; lsuData = 32'h0000_0099;
        tick();
        total++;
        if (pendingMask !== 32'h0 || regWriteEnable !== 1'b1 || writeRegAddr !== 5'd9 || writeData !== 32'h99) begin
            bad++; $display("FAIL lsu9_clear: got mask=%h we=%0b addr=%0d data=%h want 0 1 9 99",
                pendingMask, regWriteEnable, writeRegAddr, writeData);
        end
        lsuValid = 0; issueValid = 1; issueRegAddr = 5'd10;
        tick();
        issueRegAddr = 5'd11; lsuValid = 1; lsuRegAddr = 5'd10; lsuData = 32'hCAFE_0010;
        tick();
        lsuValid = 0; issueValid = 0;
        total++;
        if (pendingMask !== 32'h800 || lsuError !== 1'b0) begin
            bad++; $display("FAIL set_clear_same_cycle: got mask=%h err=%0b want 00000800 0", pendingMask, lsuError);
        end
    endtask

    task automatic test_zero_reg();
        issueValid = 1; issueRegAddr = 5'd0;
        #1;
        total++;
        if (issueAccept !== 1'b1) begin
            bad++; $display("FAIL zero_issue_accept: got %0b want 1", issueAccept);
        end
        tick();
        issueValid = 0;
        total++;
        if (pendingMask !== 32'h800) begin
            bad++; $display("FAIL zero_issue_mask: got %h want 00000800", pendingMask);
        end
        lsuValid = 1; lsuRegAddr = 5'd0; lsuData = 32'h0BAD_0000;
        #1;
        total++;
        if (lsuReady !== 1'b1) begin
            bad++; $display("FAIL zero_lsu_ready: got %0b want 1", lsuReady);
        end
        tick();
        lsuValid = 0;
        total++;
        if (regWriteEnable !== 1'b0 || lsuError !== 1'b0) begin
            bad++; $display("FAIL zero_lsu_write: got we=%0b err=%0b want 0 0", regWriteEnable, lsuError);
        end
    endtask

    task automatic test_starvation();
        aluValid = 1; aluRegAddr = 5'd12; lsuValid = 1; lsuRegAddr = 5'd11; lsuData = 32'h5555_0011;
        for (int k = 0; k <= SMAX; k++) begin
            aluData = 32'hA000_0000 + k;
            total++;
            if (aluStall !== 1'b0) begin
                bad++; $display("FAIL starve_early_stall: cycle %0d got %0b want 0", k, aluStall);
            end
            tick();
        end
        total++;
        if (aluStall !== 1'b1) begin
            bad++; $display("FAIL starve_bubble: got aluStall=%0b want 1", aluStall);
        end
        aluValid = 0;
        #1;
        total++;
        if (lsuReady !== 1'b1) begin
            bad++; $display("FAIL starve_lsu_ready: got %0b want 1", lsuReady);
        end
        tick();
        lsuValid = 0;
        total++;
        if (regWriteEnable !== 1'b1 || writeRegAddr !== 5'd11 || writeData !== 32'h5555_0011 ||
            pendingMask !== 32'h0 || aluStall !== 1'b0) begin
            bad++; $display("FAIL starve_lsu_write: got we=%0b addr=%0d data=%h mask=%h stall=%0b want 1 11 55550011 0 0",
                regWriteEnable, writeRegAddr, writeData, pendingMask, aluStall);
        end
    endtask

    task automatic test_error();
        lsuValid = 1; lsuRegAddr = 5'd5; lsuData = 32'hE000_0005;
        tick();
        lsuValid = 0;
        total++;
        if (regWriteEnable !== 1'b1 || writeRegAddr !== 5'd5 || lsuError !== 1'b1) begin
            bad++; $display("FAIL error_set: got we=%0b addr=%0d err=%0b want 1 5 1", regWriteEnable, writeRegAddr, lsuError);
        end
        repeat (3) tick();
        total++;
        if (lsuError !== 1'b1) begin
            bad++; $display("FAIL error_sticky: got %0b want 1", lsuError);
        end
        issueValid = 1; issueRegAddr = 5'd6; aluValid = 1; aluRegAddr = 5'd8; aluData = 32'h8;
        tick();
        #2 rst_n = 0;
        #1;
        total++;
        if (lsuError !== 1'b0 || pendingMask !== 32'h0 || regWriteEnable !== 1'b0) begin
            bad++; $display("FAIL async_reset: got err=%0b mask=%h we=%0b want 0 0 0", lsuError, pendingMask, regWriteEnable);
        end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1; idle_inputs();
        tick();
        total++;
        if (regWriteEnable !== 1'b0 || lsuError !== 1'b0 || pendingMask !== 32'h0) begin
            bad++; $display("FAIL after_release: got we=%0b err=%0b mask=%h want 0 0 0", regWriteEnable, lsuError, pendingMask);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if (!(lsuValid && !m_last_xfer)) begin
                lsuValid   = ($urandom % 3) != 0;
                lsuRegAddr = 5'($urandom % 8);
                if (m_mask != 0 && ($urandom % 5) != 0) begin
                    int start;
                    start = $urandom % 32;
                    for (int j = 0; j < 32; j++) begin
                        if (m_mask[(start + j) % 32]) begin
                            lsuRegAddr = 5'((start + j) % 32);
                            break;
                        end
                    end
                end
                lsuData = $urandom;
            end
            aluValid     = ($urandom % 4) != 0;
            aluRegAddr   = 5'($urandom % 32);
            aluData      = $urandom;
            issueValid   = ($urandom % 2) != 0;
            issueRegAddr = 5'($urandom % 8);
            if (lsuValid && issueRegAddr == lsuRegAddr) issueValid = 0;
            #1;
            total++;
            if (lsuReady !== exp_ready() || issueAccept !== exp_accept()) begin
                bad++; $display("FAIL rand_comb[%0d]: got ready=%0b accept=%0b want %0b %0b",
                    n, lsuReady, issueAccept, exp_ready(), exp_accept());
            end
            tick();
            total++;
            if (regWriteEnable !== m_we || writeRegAddr !== m_addr || writeData !== m_data ||
                pendingMask !== m_mask || lsuError !== m_err || aluStall !== m_stall) begin
                bad++; $display("FAIL rand_state[%0d]: got we=%0b a=%0d d=%h m=%h e=%0b s=%0b want %0b %0d %h %h %0b %0b",
                    n, regWriteEnable, writeRegAddr, writeData, pendingMask, lsuError, aluStall,
                    m_we, m_addr, m_data, m_mask, m_err, m_stall);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_collision();
        test_scoreboard();
        test_zero_reg();
        test_starvation();
        test_error();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_writeback_arbiter.md
# reg_writeback_arbiter

Write-back stage that owns the register file's single write port (`regWriteEnable`, `writeRegAddr`, `writeData`) and multiplexes two producers onto it: the fixed-latency ALU pipeline and the variable-latency load/store unit (LSU). It keeps a 32-bit pending-destination scoreboard for LSU operations, so issue logic can detect hazards. It also bounds LSU starvation with a counter that requests a one-cycle ALU bubble. It sits between execute/memory and the register file.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `STARVE_MAX`, 4, consecutive blocked-LSU cycles before a bubble is requested (range 1..15)

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `aluValid`  in  1  ALU result present this cycle (cannot be back-pressured)
- `aluRegAddr`  in  ADDR_W  ALU destination
- `aluData`  in  DATA_W  ALU result
- `lsuValid`  in  1  LSU result offered
- `lsuReady`  out  1  LSU result accepted this cycle (combinational)
- `lsuRegAddr`  in  ADDR_W  LSU destination
- `lsuData`  in  DATA_W  LSU result
- `issueValid`  in  1  LSU op requesting destination reservation
- `issueRegAddr`  in  ADDR_W  destination to reserve
- `issueAccept`  out  1  reservation granted (combinational)
- `aluStall`  out  1  registered; upstream must not present `aluValid` next cycle
- `regWriteEnable`  out  1  registered write strobe to register file
- `writeRegAddr`  out  ADDR_W  registered write address
- `writeData`  out  DATA_W  registered write data
- `pendingMask`  out  32  registered scoreboard, bit i = register i awaiting LSU
- `lsuError`  out  1  sticky: LSU wrote a register that was not pending

## Operation
- Arbitration: ALU has absolute priority. `lsuReady = rst_n & ~aluValid`. LSU transfer = `lsuValid & lsuReady`. LSU must hold valid/addr/data stable until transfer.
- Write port next state: ALU valid → ALU addr/data. Else LSU transfer → LSU addr/data. Else `regWriteEnable` = 0; addr/data hold their last values.
- Destination 0: the transfer is consumed normally, but `regWriteEnable` stays 0.
- Scoreboard: `issueAccept = issueValid & ~pendingMask[issueRegAddr]` (always 1 for addr 0; 0 during reset).
  - Accepted issue with nonzero addr sets the bit.
  - LSU transfer clears bit `lsuRegAddr`.
  - Set and clear of different bits in the same cycle both take effect.
  - Same-bit set+clear cannot occur, because the pending bit blocks acceptance.
- Error: an LSU transfer to a nonzero addr whose pending bit is 0 sets `lsuError`, which is cleared only by reset. The write still happens.
- ALU writes do not consult or alter the scoreboard. WAW avoidance is upstream's job.
- Starvation counter (4 bits):
  - Increments each cycle `lsuValid & aluValid`.
  - Resets to 0 on any LSU transfer or when `lsuValid` = 0.
  - When the counter equals `STARVE_MAX`, `aluStall` is 1 the next cycle and the counter resets.
  - If `aluValid` is nonetheless high during the bubble, ALU still wins and counting resumes.

## Timing
- Reset values: `regWriteEnable` 0, `writeRegAddr` 0, `writeData` 0, `pendingMask` 0, `lsuError` 0, `aluStall` 0, counter 0.
- Reset is asynchronous and may hit mid-operation. In-flight reservations are discarded, and no write is emitted on the first edge after release.
- Latency: a source accepted in cycle N appears on the write port in cycle N+1. It lands in the register file at the end of N+1.
- `pendingMask` updates at the edge ending the issue/transfer cycle, so a cleared bit is visible in N+1. The consumer of the LSU result must also wait for the write in N+1.
- Throughput: one write per cycle. With `aluValid` continuously high, the LSU waits at most `STARVE_MAX`+1 cycles plus one bubble, given a compliant upstream.

## Structure
- Shared package `cpu_defs_pkg`: `DATA_W`, `REG_ADDR_W`, `REG_ZERO` (5'd0), `STARVE_MAX` default.
- Sub-module `wb_scoreboard`: the 32-bit pending mask with set/clear ports, `issueAccept` generation, and error detection.
- Arbitration, the starvation counter, and the write-port registers stay in the top module.

## Test plan
- Reset: hold `rst_n`=0 with `aluValid`=1 → all outputs 0 and `lsuReady`=0. Release; ALU {addr 3, 0xDEADBEEF} → next cycle `regWriteEnable`=1, addr 3, data 0xDEADBEEF.
- Collision: `aluValid` and `lsuValid` both 1 → ALU written first and `lsuReady`=0. With `aluValid` 0 the following cycle, LSU {addr 7, 0x12345678} is written one cycle later.
- Scoreboard:
  - Issue addr 9 → `issueAccept`=1 and `pendingMask`=0x200.
  - Second issue to 9 → `issueAccept`=0.
  - LSU transfer to 9 → mask 0 the next cycle and the write occurs.
- Zero register: issue addr 0 → accept=1 with mask unchanged. LSU to addr 0 → transfer completes, `regWriteEnable` stays 0, `lsuError` stays 0.
- Starvation (`STARVE_MAX`=4): `aluValid` and `lsuValid` held high → `aluStall`=1 in the fifth cycle after the counter starts. Drop `aluValid` for that cycle → LSU transfer completes.
- Error: LSU transfer to addr 5 with no reservation → write occurs and `lsuError`=1. It stays 1 until `rst_n` is pulsed low.
